// File: rtl/decomp_pkg.sv
// Shared types and widths for the codebook-lookup sequencer (decomp_seq).
package decomp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned TAG_W         = 6;
    localparam int unsigned WORD_W        = 24;
    localparam int unsigned TAGS_PER_WORD = 4;
    localparam int unsigned CB_AW         = 6;
    localparam int unsigned CNT_W         = 3;

endpackage

// File: rtl/decomp_seq_tag_unpacker.sv
// Tag buffer for DECODE: holds one stream word, emits its four 6-bit tags
// lowest first, and asks for the next word early enough for 1 tag/cycle.
module decomp_seq_tag_unpacker
    import decomp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              want,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              tag_vld,
    output logic [TAG_W-1:0]  tag,
    output logic [CNT_W-1:0]  buf_cnt
);

    logic [WORD_W-1:0] tag_buf;
    logic [CNT_W-1:0]  cnt_q;

    // Ready while empty or on the last tag so a reload can follow without a gap.
    assign in_ready = en && want && (cnt_q <= CNT_W'(1));
    assign tag_vld  = en && (cnt_q != '0);
    assign tag      = tag_buf[TAG_W-1:0];
    assign buf_cnt  = cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            tag_buf <= '0;
            cnt_q   <= '0;
        end else if (in_ready && in_valid) begin
            tag_buf <= in_data;
            cnt_q   <= CNT_W'(TAGS_PER_WORD);
        end else if (tag_vld) begin
            tag_buf <= tag_buf >> TAG_W;
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/decomp_seq.sv
// Sequencer feeding the codebook-lookup stage: loads CB_SIZE codewords, then
// streams packed tags as lookups with aligned pixel writes.
// Optional tag range check: define DECOMP_TAG_RANGE_CHK_EN.
module decomp_seq
    import decomp_pkg::*;
#(
    parameter int unsigned CB_SIZE = 64,
    parameter int unsigned NUM_PIX = 4096,
    parameter int unsigned PA_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic              weight_en,
    output logic [CB_AW-1:0]  weight_A,
    output logic [WORD_W-1:0] weight_data,
    output logic              tag_en,
    output logic [TAG_W-1:0]  tag_A,
    output logic              pix_we,
    output logic [PA_W-1:0]   pix_A,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned PC_W = PA_W + 1;

    state_t            state_q, state_d;
    logic [CB_AW-1:0]  load_cnt;
    logic [PA_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]  buf_cnt;
    logic [TAG_W-1:0]  tag;
    logic              tag_vld;
    logic              dec_ready;
    logic              want;
    logic              start_ok;
    logic              load_accept;
    logic              last_load;
    logic              last_pix;

    assign start_ok    = start && (state_q == IDLE || state_q == DONE);
    assign load_accept = (state_q == LOAD) && in_valid;
    assign last_load   = load_accept && (load_cnt == CB_AW'(CB_SIZE - 1));
    assign last_pix    = tag_vld && (pix_cnt == PA_W'(NUM_PIX - 1));
    // Stop accepting once buffered tags already cover the rest of the image.
    assign want        = (PC_W'(pix_cnt) + PC_W'(buf_cnt)) < PC_W'(NUM_PIX);

    decomp_seq_tag_unpacker u_unpack (
        .clk      (clk),
        .rst      (rst),
        .clear    (start_ok),
        .en       (state_q == DECODE),
        .want     (want),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (dec_ready),
        .tag_vld  (tag_vld),
        .tag      (tag),
        .buf_cnt  (buf_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start)     state_d = LOAD;
            LOAD:       if (last_load) state_d = DECODE;
            DECODE:     if (last_pix)  state_d = DONE;
            default:                   state_d = IDLE;
        endcase
    end

    // Codeword write port and image counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt    <= '0;
            pix_cnt     <= '0;
            weight_en   <= 1'b0;
            weight_A    <= '0;
            weight_data <= '0;
        end else begin
            weight_en <= load_accept;
            if (load_accept) begin
                weight_A    <= load_cnt;
                weight_data <= in_data;
                load_cnt    <= load_cnt + CB_AW'(1);
            end
            if (start_ok) begin
                load_cnt <= '0;
                pix_cnt  <= '0;
            end else if (tag_vld) begin
                pix_cnt <= pix_cnt + PA_W'(1);
            end
        end
    end

    assign in_ready = (state_q == LOAD) || dec_ready;
    assign tag_en   = tag_vld;
    assign pix_we   = tag_vld;
    assign tag_A    = tag_vld ? tag : '0;
    assign pix_A    = tag_vld ? pix_cnt : '0;
    assign busy     = (state_q == LOAD) || (state_q == DECODE);
    assign done     = (state_q == DONE);

`ifdef DECOMP_TAG_RANGE_CHK_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (rst || start_ok)
            err_q <= 1'b0;
        else if (tag_vld && ({1'b0, tag} >= (TAG_W + 1)'(CB_SIZE)))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_decomp_seq.sv
// Directed bench for decomp_seq with NUM_PIX=16: codebook load, tag order,
// throughput/bubbles, completion, restart, range check and mid-decode reset.
module tb_decomp_seq;

    localparam int unsigned PA_W    = 12;
    localparam int unsigned NUM_PIX = 16;
`ifdef DECOMP_TAG_RANGE_CHK_EN
    localparam int unsigned CB  = 16;
    localparam bit          CHK = 1'b1;
`else
    localparam int unsigned CB  = 64;
    localparam bit          CHK = 1'b0;
`endif

    localparam logic [23:0] W1 = 24'hFC5083;  // tags 3,2,5,63
    localparam logic [23:0] W2 = 24'h34C2CA;  // tags 10,11,12,13
    localparam logic [23:0] W3 = 24'h103081;  // tags 1,2,3,4
    localparam logic [23:0] W4 = 24'h2481D4;  // tags 20,7,8,9

    logic              clk = 1'b0;
    logic              rst, start, in_valid;
    logic [23:0]       in_data;
    logic              in_ready, weight_en, tag_en, pix_we, busy, done, err;
    logic [5:0]        weight_A, tag_A;
    logic [23:0]       weight_data;
    logic [PA_W-1:0]   pix_A;

    decomp_seq #(.CB_SIZE(CB), .NUM_PIX(NUM_PIX), .PA_W(PA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_data(in_data), .weight_en(weight_en),
        .weight_A(weight_A), .weight_data(weight_data), .tag_en(tag_en),
        .tag_A(tag_A), .pix_we(pix_we), .pix_A(pix_A), .busy(busy),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic        v;
        logic [23:0] d;
        logic        rdy;
        logic        ten;
        logic [5:0]  ta;
        logic [11:0] pa;
        logic        dn;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cb(input logic [23:0] base);
        for (int i = 0; i < int'(CB); i++) begin
            in_valid = 1'b1;
            in_data  = base + 24'(i);
            #2;
            chk("load_ready", 32'(in_ready), 32'd1);
            if (i > 0) begin
                chk("weight_en", 32'(weight_en), 32'd1);
                chk("weight_A", 32'(weight_A), 32'(i - 1));
                chk("weight_data", 32'(weight_data), 32'(base + 24'(i - 1)));
            end else begin
                chk("weight_en_first", 32'(weight_en), 32'd0);
            end
            next_cycle();
        end
        in_valid = 1'b0;
        #2;
        chk("weight_en_last", 32'(weight_en), 32'd1);
        chk("weight_A_last", 32'(weight_A), 32'(CB - 1));
        chk("weight_data_last", 32'(weight_data), 32'(base + 24'(CB - 1)));
        chk("decode_ready", 32'(in_ready), 32'd1);
        chk("decode_busy", 32'(busy), 32'd1);
        chk("decode_no_tag", 32'(tag_en), 32'd0);
        next_cycle();
    endtask

    initial begin
        logic err_model;
        err_model = 1'b0;

        tbl[0]  = '{1'b1, W1,    1'b1, 1'b0, 6'd0,  12'd0,  1'b0};
        tbl[1]  = '{1'b1, W2,    1'b0, 1'b1, 6'd3,  12'd0,  1'b0};
        tbl[2]  = '{1'b1, W2,    1'b0, 1'b1, 6'd2,  12'd1,  1'b0};
        tbl[3]  = '{1'b1, W2,    1'b0, 1'b1, 6'd5,  12'd2,  1'b0};
        tbl[4]  = '{1'b1, W2,    1'b1, 1'b1, 6'd63, 12'd3,  1'b0};
        tbl[5]  = '{1'b1, W3,    1'b0, 1'b1, 6'd10, 12'd4,  1'b0};
        tbl[6]  = '{1'b1, W3,    1'b0, 1'b1, 6'd11, 12'd5,  1'b0};
        tbl[7]  = '{1'b1, W3,    1'b0, 1'b1, 6'd12, 12'd6,  1'b0};
        tbl[8]  = '{1'b0, W3,    1'b1, 1'b1, 6'd13, 12'd7,  1'b0};
        tbl[9]  = '{1'b0, W3,    1'b1, 1'b0, 6'd0,  12'd0,  1'b0};
        tbl[10] = '{1'b1, W3,    1'b1, 1'b0, 6'd0,  12'd0,  1'b0};
        tbl[11] = '{1'b0, W4,    1'b0, 1'b1, 6'd1,  12'd8,  1'b0};
        tbl[12] = '{1'b0, W4,    1'b0, 1'b1, 6'd2,  12'd9,  1'b0};
        tbl[13] = '{1'b0, W4,    1'b0, 1'b1, 6'd3,  12'd10, 1'b0};
        tbl[14] = '{1'b1, W4,    1'b1, 1'b1, 6'd4,  12'd11, 1'b0};
        tbl[15] = '{1'b1, W4,    1'b0, 1'b1, 6'd20, 12'd12, 1'b0};
        tbl[16] = '{1'b1, 24'd0, 1'b0, 1'b1, 6'd7,  12'd13, 1'b0};
        tbl[17] = '{1'b1, 24'd0, 1'b0, 1'b1, 6'd8,  12'd14, 1'b0};
        tbl[18] = '{1'b1, 24'd0, 1'b0, 1'b1, 6'd9,  12'd15, 1'b0};
        tbl[19] = '{1'b1, 24'd0, 1'b0, 1'b0, 6'd0,  12'd0,  1'b1};
        tbl[20] = '{1'b1, 24'd0, 1'b0, 1'b0, 6'd0,  12'd0,  1'b1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_weight_en", 32'(weight_en), 32'd0);
        chk("rst_tag_en", 32'(tag_en), 32'd0);
        chk("rst_pix_A", 32'(pix_A), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        next_cycle();

        // First image.
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        load_cb(24'h000000);

        for (int r = 0; r < 21; r++) begin
            in_valid = tbl[r].v;
            in_data  = tbl[r].d;
            #2;
            if (in_ready !== tbl[r].rdy || tag_en !== tbl[r].ten || tag_A !== tbl[r].ta ||
                pix_A !== tbl[r].pa || done !== tbl[r].dn)
                $display("row %0d: ready=%0b tag_en=%0b tag_A=%0d pix_A=%0d done=%0b",
                         r, in_ready, tag_en, tag_A, pix_A, done);
            chk("in_ready", 32'(in_ready), 32'(tbl[r].rdy));
            chk("tag_en", 32'(tag_en), 32'(tbl[r].ten));
            chk("pix_we", 32'(pix_we), 32'(tbl[r].ten));
            chk("tag_A", 32'(tag_A), 32'(tbl[r].ta));
            chk("pix_A", 32'(pix_A), 32'(tbl[r].pa));
            chk("done", 32'(done), 32'(tbl[r].dn));
            chk("busy", 32'(busy), 32'(!tbl[r].dn));
            chk("weight_idle", 32'(weight_en), 32'd0);
            chk("err", 32'(err), 32'(err_model));
            if (CHK && tbl[r].ten && (32'(tbl[r].ta) >= CB)) err_model = 1'b1;
            next_cycle();
        end

        // Restart from DONE.
        start = 1'b1; in_valid = 1'b0;
        #2;
        chk("pre_restart_done", 32'(done), 32'd1);
        next_cycle();
        start = 1'b0;
        #2;
        chk("restart_done", 32'(done), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        chk("restart_ready", 32'(in_ready), 32'd1);
        chk("restart_err", 32'(err), 32'd0);
        load_cb(24'hA00000);

        // Tag 20 then zeros; range error follows the issuing cycle only with the check built.
        in_valid = 1'b1; in_data = 24'h000014;
        #2;
        chk("rc_ready", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b1; in_data = 24'h000000;
        #2;
        chk("rc_tag20", 32'(tag_A), 32'd20);
        chk("rc_err_before", 32'(err), 32'd0);
        next_cycle();
        in_valid = 1'b0;
        #2;
        chk("rc_err_set", 32'(err), 32'(CHK));
        next_cycle();
        #2;
        chk("rc_err_sticky", 32'(err), 32'(CHK));
        chk("rc_pix2", 32'(pix_A), 32'd2);
        next_cycle();
        in_valid = 1'b1;
        #2;
        chk("rc_pix3", 32'(pix_A), 32'd3);
        chk("rc_reload_ready", 32'(in_ready), 32'd1);
        next_cycle();
        in_valid = 1'b0;
        #2;
        chk("rc_pix4", 32'(pix_A), 32'd4);
        next_cycle();

        // Reset while pix_A is 5.
        rst = 1'b1;
        #2;
        chk("mid_pix5", 32'(pix_A), 32'd5);
        chk("mid_tag_en", 32'(tag_en), 32'd1);
        next_cycle();
        rst = 1'b0; in_valid = 1'b1; in_data = 24'h123456;
        #2;
        chk("mr_tag_en", 32'(tag_en), 32'd0);
        chk("mr_pix_we", 32'(pix_we), 32'd0);
        chk("mr_tag_A", 32'(tag_A), 32'd0);
        chk("mr_pix_A", 32'(pix_A), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_weight_en", 32'(weight_en), 32'd0);
        chk("mr_weight_A", 32'(weight_A), 32'd0);
        chk("mr_weight_data", 32'(weight_data), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_err", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            #2;
            chk("idle_ready", 32'(in_ready), 32'd0);
            chk("idle_weight_en", 32'(weight_en), 32'd0);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
